// File: rtl/alu_defs_pkg.sv
// Shared constants for the ALU issue/writeback stage.
// Opcodes, MIPS field codes and FSM state encoding.
package alu_defs_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// 32x32 register file: two async read ports, one debug port,
// one synchronous write port; r0 is hardwired to zero.
module reg_file_32x32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_ra_addr,
    output logic [31:0] o_ra_data,
    input  logic [4:0]  i_rb_addr,
    output logic [31:0] o_rb_data,
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_ra_data  = (i_ra_addr  == 5'd0) ? '0 : r_mem[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == 5'd0) ? '0 : r_mem[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around an external combinational ALU.
// One instruction per fixed IDLE-READ-EXEC-WB sequence.
module alu_issue_stage
    import alu_defs_pkg::*;
#(
    parameter bit SUPPRESS_WB_ON_OF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        done_valid,
    output logic        done_zf,
    output logic        done_of,
    output logic        done_illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_t      r_state;
    logic [31:0] r_instr;
    logic [4:0]  r_dest;
    logic        r_legal;
    logic        r_addsub;
    logic        r_wb_en;
    logic [31:0] r_f;

    logic [5:0]  w_opc;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_sx;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic        w_rtype;
    logic        w_addiu;
    logic        w_legal;
    logic        w_b_imm;
    logic        w_addsub;
    logic [2:0]  w_alu_op;
    logic        w_we;

    assign w_opc    = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_rd     = r_instr[15:11];
    assign w_funct  = r_instr[5:0];
    assign w_imm_sx = {{16{r_instr[15]}}, r_instr[15:0]};
    assign w_rtype  = (w_opc == OP_RTYPE);
    assign w_addiu  = (w_opc == OP_ADDIU);

    always_comb begin
        w_alu_op = ALU_AND;
        w_legal  = 1'b1;
        w_b_imm  = 1'b0;
        w_addsub = 1'b0;
        unique case (1'b1)
            w_rtype && (w_funct == FUNCT_AND):  w_alu_op = ALU_AND;
            w_rtype && (w_funct == FUNCT_OR):   w_alu_op = ALU_OR;
            w_rtype && (w_funct == FUNCT_XOR):  w_alu_op = ALU_XOR;
            w_rtype && (w_funct == FUNCT_NOR):  w_alu_op = ALU_NOR;
            w_rtype && (w_funct == FUNCT_ADD): begin
                w_alu_op = ALU_ADD;
                w_addsub = 1'b1;
            end
            w_rtype && (w_funct == FUNCT_SUB): begin
                w_alu_op = ALU_SUB;
                w_addsub = 1'b1;
            end
            w_rtype && (w_funct == FUNCT_SLTU): w_alu_op = ALU_SLTU;
            w_rtype && (w_funct == FUNCT_SLLV): w_alu_op = ALU_SLL;
            w_addiu: begin
                w_alu_op = ALU_ADD;
                w_b_imm  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // The write lands at the WB->IDLE edge, before any later READ.
    assign w_we = (r_state == S_WB) && r_wb_en;

    reg_file_32x32 u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ra_addr  (w_rs),
        .o_ra_data  (w_rs_data),
        .i_rb_addr  (w_rt),
        .o_rb_data  (w_rt_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
        .i_we       (w_we),
        .i_wa       (r_dest),
        .i_wd       (r_f)
    );

    assign instr_ready = (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_instr      <= '0;
            r_dest       <= '0;
            r_legal      <= 1'b0;
            r_addsub     <= 1'b0;
            r_wb_en      <= 1'b0;
            r_f          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            done_valid   <= 1'b0;
            done_zf      <= 1'b0;
            done_of      <= 1'b0;
            done_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    alu_a    <= w_legal ? w_rs_data : '0;
                    alu_b    <= !w_legal ? '0 :
                                (w_b_imm ? w_imm_sx : w_rt_data);
                    alu_op   <= w_alu_op;
                    r_dest   <= w_b_imm ? w_rt : w_rd;
                    r_legal  <= w_legal;
                    r_addsub <= w_addsub;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_f          <= alu_f;
                    done_zf      <= alu_zf;
                    done_of      <= alu_of;
                    done_illegal <= !r_legal;
                    done_valid   <= 1'b1;
                    r_wb_en      <= r_legal && (r_dest != 5'd0) &&
                                    !(SUPPRESS_WB_ON_OF && alu_of && r_addsub);
                    r_state      <= S_WB;
                end
                S_WB: begin
                    done_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with an external ALU model
// and an instruction-level register file reference.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_op;
    logic        alu_zf, alu_of;
    logic        done_valid, done_zf, done_of, done_illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_stage #(.SUPPRESS_WB_ON_OF(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_f        (alu_f),
        .alu_zf       (alu_zf),
        .alu_of       (alu_of),
        .done_valid   (done_valid),
        .done_zf      (done_zf),
        .done_of      (done_of),
        .done_illegal (done_illegal),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // External combinational ALU
    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (alu_op)
            3'd0: alu_f = alu_a & alu_b;
            3'd1: alu_f = alu_a | alu_b;
            3'd2: alu_f = alu_a ^ alu_b;
            3'd3: alu_f = ~(alu_a | alu_b);
            3'd4: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd5: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd6: alu_f = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_f = (alu_a >= 32) ? 32'd0 : (alu_b << alu_a[4:0]);
        endcase
        alu_zf = (alu_f == 32'd0);
    end

    typedef struct {
        logic zf;
        logic of;
        logic ill;
        time  t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    int          checks = 0;
    int          errors = 0;
    bit          hold = 0;

    function automatic logic [31:0] rt_i(input logic [5:0] f, input int rd,
                                         input int rs, input int rt);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, f};
    endfunction

    function automatic logic [31:0] addiu_i(input int rt, input int rs,
                                            input logic [15:0] imm);
        return {6'h09, rs[4:0], rt[4:0], imm};
    endfunction

    // Instruction-level semantics: result, flags, architectural write
    task automatic model_exec(input logic [31:0] ins, output exp_t e);
        logic [31:0] a, b, res;
        logic        ok, of, addsub;
        int          dest;
        a = m_regs[ins[25:21]];
        b = m_regs[ins[20:16]];
        res = 0; of = 0; ok = 1; addsub = 0;
        dest = ins[15:11];
        if (ins[31:26] == 6'h09) begin
            b = {{16{ins[15]}}, ins[15:0]};
            res = a + b;
            of = (a[31] == b[31]) && (res[31] != a[31]);
            dest = ins[20:16];
        end else if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h20: begin
                    res = a + b; addsub = 1;
                    of = (a[31] == b[31]) && (res[31] != a[31]);
                end
                6'h22: begin
                    res = a - b; addsub = 1;
                    of = (a[31] != b[31]) && (res[31] != a[31]);
                end
                6'h2B: res = (a < b) ? 1 : 0;
                6'h04: res = (a >= 32) ? 0 : b << a;
                default: ok = 0;
            endcase
        end else begin
            ok = 0;
        end
        if (ok && dest != 0 && !(addsub && of)) m_regs[dest] = res;
        e.zf = (res == 0);
        e.of = of;
        e.ill = !ok;
        e.t = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        exp_t e;
        int   n = 0;
        instr_valid = 1'b1;
        instr = ins;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_exec(ins, e);
        e.t = $time + 25;
        q.push_back(e);
        @(negedge clk);
        if (hold) instr = $urandom;
        else instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        instr_valid = 1'b0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic dbg_rd(input int a, output logic [31:0] d);
        @(negedge clk);
        dbg_addr = a[4:0];
        #1 d = dbg_data;
    endtask

    task automatic dump_cmp(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            dbg_rd(i, d);
            chk($sformatf("%s_r%0d", tag, i), d, m_regs[i]);
        end
    endtask

    // Monitor: every retirement must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_valid=1 with nothing in flight");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (done_zf !== e.zf || done_of !== e.of ||
                    done_illegal !== e.ill || $time != e.t) begin
                    errors++;
                    $display("FAIL done: zf/of/ill=%b%b%b t=%0t expected %b%b%b t=%0t",
                             done_zf, done_of, done_illegal, $time,
                             e.zf, e.of, e.ill, e.t);
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        exp_t        ex;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", instr_ready, 1);
        chk("reset_done", done_valid, 0);
        dump_cmp("reset");

        issue(addiu_i(1, 0, 16'd5));
        issue(addiu_i(2, 0, 16'd3));
        issue(rt_i(6'h20, 3, 1, 2));
        issue(rt_i(6'h22, 4, 1, 1));
        issue(rt_i(6'h2B, 9, 2, 1));
        issue(rt_i(6'h27, 10, 0, 0));
        issue(addiu_i(5, 0, 16'hFFFF));
        issue(addiu_i(8, 0, 16'd31));
        issue(rt_i(6'h04, 6, 8, 5));
        issue(rt_i(6'h22, 7, 6, 1));
        hold = 1;
        issue(rt_i(6'h3F, 11, 1, 2));
        issue(rt_i(6'h20, 0, 1, 2));
        hold = 0;
        issue({6'h23, 26'h0123456});
        drain();

        dbg_rd(3, d);  chk("r3_add", d, 32'd8);
        dbg_rd(4, d);  chk("r4_sub", d, 32'd0);
        dbg_rd(9, d);  chk("r9_sltu", d, 32'd1);
        dbg_rd(10, d); chk("r10_nor", d, 32'hFFFFFFFF);
        dbg_rd(6, d);  chk("r6_sllv", d, 32'h80000000);
        dbg_rd(7, d);  chk("r7_of_suppressed", d, 32'd0);
        dbg_rd(0, d);  chk("r0_zero", d, 32'd0);
        dbg_rd(11, d); chk("r11_illegal_nowrite", d, 32'd0);
        dump_cmp("directed");

        for (int k = 0; k < 200; k++) begin
            int          kind;
            logic [5:0]  fl [8];
            fl = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};
            kind = $urandom_range(0, 10);
            hold = ($urandom_range(0, 1) == 1);
            if (kind < 8)
                issue(rt_i(fl[kind], $urandom_range(0, 7),
                           $urandom_range(0, 7), $urandom_range(0, 7)));
            else if (kind < 10)
                issue(addiu_i($urandom_range(0, 7), $urandom_range(0, 7),
                              16'($urandom)));
            else
                issue({6'h00, 20'($urandom), 6'h3F});
        end
        hold = 0;
        drain();
        dump_cmp("random");

        issue(rt_i(6'h20, 3, 1, 2));
        @(posedge clk);
        #2 rst_n = 1'b0;
        void'(q.pop_back());
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        @(negedge clk);
        chk("midreset_done", done_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", instr_ready, 1);
        repeat (4) @(negedge clk);
        chk("midreset_queue", q.size(), 0);
        dump_cmp("midreset");

        ex.zf = 0;
        issue(addiu_i(12, 0, 16'd7));
        drain();
        dbg_rd(12, d); chk("post_reset_addiu", d, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
